// File: rtl/command_encoder_pkg.sv
// -----------------------------------------------------------------------------
// command_encoder_pkg
// Shared definitions for the 1-byte RGB command protocol: command opcodes,
// command/response byte prefixes, response status codes and the encode/parse
// helpers. The responder-side decoder uses the same package so both ends agree
// on the byte layout.
// -----------------------------------------------------------------------------
package command_encoder_pkg;

    // cmd_op codes
    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_TOGGLE = 2'b10;
    localparam logic [1:0] OP_RAW    = 2'b11;

    // Command byte patterns
    localparam logic [7:0] CMD_NOP_BYTE   = 8'h20;
    localparam logic [4:0] CMD_SET_PFX    = 5'b10000;
    localparam logic [4:0] CMD_TOGGLE_PFX = 5'b01000;

    // Response byte prefixes
    localparam logic [4:0] RSP_OK_PFX  = 5'b00000;
    localparam logic [4:0] RSP_ERR_PFX = 5'b11111;

    typedef enum logic [1:0] {
        RSP_OK         = 2'b00,
        RSP_DECODE_ERR = 2'b01,
        RSP_TIMEOUT    = 2'b10,
        RSP_MALFORMED  = 2'b11
    } rsp_status_e;

    typedef struct packed {
        rsp_status_e status;
        logic [2:0]  data;
    } rsp_t;

    function automatic logic [7:0] encode_cmd(input logic [1:0] op,
                                              input logic [2:0] rgb,
                                              input logic [7:0] raw);
        logic [7:0] b;
        case (op)
            OP_NOP:    b = CMD_NOP_BYTE;
            OP_SET:    b = {CMD_SET_PFX, rgb};
            OP_TOGGLE: b = {CMD_TOGGLE_PFX, rgb};
            default:   b = raw;
        endcase
        return b;
    endfunction

    // The top five bits classify the reply; the low three carry the payload.
    function automatic rsp_t parse_rsp(input logic [7:0] b);
        rsp_t r;
        if (b[7:3] == RSP_OK_PFX) begin
            r.status = RSP_OK;
            r.data   = b[2:0];
        end else if (b[7:3] == RSP_ERR_PFX) begin
            r.status = RSP_DECODE_ERR;
            r.data   = b[2:0];
        end else begin
            r.status = RSP_MALFORMED;
            r.data   = 3'b000;
        end
        return r;
    endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// -----------------------------------------------------------------------------
// cmd_timeout_timer
// Response timeout counter. Counts enabled cycles from a clear and saturates at
// TIMEOUT_CYCLES-1, where expired_o is asserted.
// Ports:
//   clk       in  system clock
//   reset_n   in  asynchronous active-low reset
//   clear_i   in  force count to zero (has priority over enable)
//   enable_i  in  count this cycle
//   expired_o out count has reached TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module cmd_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 120000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != TERMINAL)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == TERMINAL);

endmodule

// File: rtl/command_encoder.sv
// -----------------------------------------------------------------------------
// command_encoder
// Host-side initiator for the 1-byte RGB command protocol. Accepts a command,
// encodes it into one byte, hands it to the UART transmitter, then waits (with
// timeout) for the single response byte and reports the parsed status.
// Optional feature macro: CMD_RETRY_EN -- resend the latched byte up to
// MAX_RETRIES times after a timeout before reporting TIMEOUT.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   cmd_valid/cmd_ready       command handshake (ready only in IDLE)
//   cmd_op/cmd_rgb/cmd_raw    opcode, {b,g,r} operand, raw byte
//   snd_data/snd_ready        byte to transmitter and its valid
//   snd_busy                  transmitter busy
//   rcv_data/rcv_ready        received byte and its one-cycle strobe
//   rsp_valid                 one-cycle pulse when rsp_status/rsp_data update
//   rsp_status/rsp_data       parsed response (held until next update)
// -----------------------------------------------------------------------------
module command_encoder
    import command_encoder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 120000
`ifdef CMD_RETRY_EN
    ,
    parameter int unsigned MAX_RETRIES = 2
`endif
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [2:0] cmd_rgb,
    input  logic [7:0] cmd_raw,
    output logic [7:0] snd_data,
    output logic       snd_ready,
    input  logic       snd_busy,
    input  logic [7:0] rcv_data,
    input  logic       rcv_ready,
    output logic       rsp_valid,
    output logic [1:0] rsp_status,
    output logic [2:0] rsp_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_SEND_WAIT,
        S_RESP_WAIT,
        S_DONE
    } state_e;

    state_e     state_q;
    logic       cmd_ready_q;
    logic [7:0] byte_q;
    logic [7:0] snd_data_q;
    logic       snd_ready_q;
    logic       rsp_valid_q;
    rsp_t       rsp_q;
    logic       timer_expired;

`ifdef CMD_RETRY_EN
    localparam int unsigned RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    logic [RETRY_W-1:0] retry_q;
`endif

    // Timer is held at zero for the whole handshake so that RESP_WAIT always
    // starts counting from zero, including on a resend.
    cmd_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear_i  (state_q == S_SEND_WAIT),
        .enable_i (state_q == S_RESP_WAIT),
        .expired_o(timer_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            byte_q      <= '0;
            snd_data_q  <= '0;
            snd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
`ifdef CMD_RETRY_EN
            retry_q     <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        byte_q      <= encode_cmd(cmd_op, cmd_rgb, cmd_raw);
                        cmd_ready_q <= 1'b0;
                        state_q     <= S_SEND;
`ifdef CMD_RETRY_EN
                        retry_q     <= '0;
`endif
                    end
                end
                S_SEND: begin
                    if (!snd_busy) begin
                        snd_data_q  <= byte_q;
                        snd_ready_q <= 1'b1;
                        state_q     <= S_SEND_WAIT;
                    end
                end
                S_SEND_WAIT: begin
                    // busy rising is the transmitter's acknowledgement
                    if (snd_busy) begin
                        snd_ready_q <= 1'b0;
                        state_q     <= S_RESP_WAIT;
                    end
                end
                S_RESP_WAIT: begin
                    // a byte arriving on the expiry cycle takes precedence
                    if (rcv_ready) begin
                        rsp_q       <= parse_rsp(rcv_data);
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (timer_expired) begin
`ifdef CMD_RETRY_EN
                        if (retry_q < RETRY_W'(MAX_RETRIES)) begin
                            retry_q <= retry_q + RETRY_W'(1);
                            state_q <= S_SEND;
                        end else
`endif
                        begin
                            rsp_q       <= '{status: RSP_TIMEOUT, data: 3'b000};
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    snd_ready_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign snd_data   = snd_data_q;
    assign snd_ready  = snd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_status = rsp_q.status;
    assign rsp_data   = rsp_q.data;

endmodule

// File: tb/tb_command_encoder.sv
// -----------------------------------------------------------------------------
// tb_command_encoder
// Directed self-checking bench for command_encoder with a short timeout.
// Honours CMD_RETRY_EN for the expected number of resends on timeout.
// -----------------------------------------------------------------------------
module tb_command_encoder;

    localparam int unsigned TO = 16;
`ifdef CMD_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [2:0] cmd_rgb = 3'b000;
    logic [7:0] cmd_raw = 8'h00;
    logic [7:0] snd_data;
    logic       snd_ready;
    logic       snd_busy = 1'b0;
    logic [7:0] rcv_data = 8'h00;
    logic       rcv_ready = 1'b0;
    logic       rsp_valid;
    logic [1:0] rsp_status;
    logic [2:0] rsp_data;

    command_encoder #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rgb   (cmd_rgb),
        .cmd_raw   (cmd_raw),
        .snd_data  (snd_data),
        .snd_ready (snd_ready),
        .snd_busy  (snd_busy),
        .rcv_data  (rcv_data),
        .rcv_ready (rcv_ready),
        .rsp_valid (rsp_valid),
        .rsp_status(rsp_status),
        .rsp_data  (rsp_data)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   snd_cnt = 0;
    logic snd_prev = 1'b0;

    // count distinct send requests (rising edges of snd_ready)
    always @(posedge clk) begin
        snd_prev <= snd_ready;
        if (snd_ready && !snd_prev) snd_cnt <= snd_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] rgb, input logic [7:0] raw);
        cmd_op    = op;
        cmd_rgb   = rgb;
        cmd_raw   = raw;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // wait (bounded) for snd_ready, check the byte, then acknowledge with busy
    task automatic handshake(input string tag, input logic [7:0] exp, output int waited);
        waited = 0;
        while (!snd_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_snd_ready"}, 32'(snd_ready), 32'd1);
        check({tag, "_snd_data"}, 32'(snd_data), 32'(exp));
        snd_busy = 1'b1;
        @(negedge clk);
        check({tag, "_snd_drop"}, 32'(snd_ready), 32'd0);
        snd_busy = 1'b0;
    endtask

    task automatic respond(input string tag, input logic [7:0] b,
                           input logic [1:0] st, input logic [2:0] d);
        rcv_data  = b;
        rcv_ready = 1'b1;
        @(negedge clk);
        rcv_ready = 1'b0;
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_rsp_status"}, 32'(rsp_status), 32'(st));
        check({tag, "_rsp_data"}, 32'(rsp_data), 32'(d));
        @(negedge clk);
        check({tag, "_rsp_pulse_end"}, 32'(rsp_valid), 32'd0);
        check({tag, "_cmd_ready_back"}, 32'(cmd_ready), 32'd1);
        check({tag, "_status_held"}, 32'(rsp_status), 32'(st));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        int seen;
        int exp_snd;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_snd_ready", 32'(snd_ready), 32'd0);
        check("rst_snd_data", 32'(snd_data), 32'h00);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_status", 32'(rsp_status), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // SET 101 -> 0x85, reply 0x05 -> OK 101; cmd_valid while busy ignored
        issue(2'b01, 3'b101, 8'h00);
        check("t1_cmd_ready_low", 32'(cmd_ready), 32'd0);
        handshake("t1", 8'h85, w);
        check("t1_latency", 32'(w), 32'd1);
        cmd_op    = 2'b10;
        cmd_valid = 1'b1;
        @(negedge clk);
        check("t1_ignored_cmd", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        respond("t1", 8'h05, 2'b00, 3'b101);
        exp_snd = 1;
        check("t1_snd_count", 32'(snd_cnt), 32'(exp_snd));

        // TOGGLE 011 -> 0x43, reply 0xFC -> DECODE_ERR 100
        issue(2'b10, 3'b011, 8'h00);
        handshake("t2", 8'h43, w);
        respond("t2", 8'hFC, 2'b01, 3'b100);

        // RAW 0x33, reply 0x44 -> MALFORMED 0
        issue(2'b11, 3'b000, 8'h33);
        handshake("t3", 8'h33, w);
        respond("t3", 8'h44, 2'b11, 3'b000);
        exp_snd = 3;
        check("t3_snd_count", 32'(snd_cnt), 32'(exp_snd));

        // NOP with no reply -> TIMEOUT 16 cycles after busy is sampled
        issue(2'b00, 3'b000, 8'h00);
        for (int a = 0; a < ATTEMPTS; a++) begin
            handshake("t4", 8'h20, w);
            seen = 0;
            repeat (TO - 1) begin
                @(negedge clk);
                if (rsp_valid) seen++;
            end
            check("t4_no_early_rsp", 32'(seen), 32'd0);
            @(negedge clk);
            check("t4_rsp_valid", 32'(rsp_valid), (a == ATTEMPTS - 1) ? 32'd1 : 32'd0);
        end
        check("t4_rsp_status", 32'(rsp_status), 32'd2);
        check("t4_rsp_data", 32'(rsp_data), 32'd0);
        @(negedge clk);
        check("t4_rsp_pulse_end", 32'(rsp_valid), 32'd0);
        check("t4_cmd_ready_back", 32'(cmd_ready), 32'd1);
        exp_snd = exp_snd + ATTEMPTS;
        check("t4_snd_count", 32'(snd_cnt), 32'(exp_snd));

        // busy held at SEND for 50 cycles, then reply on the timeout cycle
        snd_busy = 1'b1;
        issue(2'b01, 3'b010, 8'h00);
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (snd_ready) seen++;
        end
        check("t5_held_off", 32'(seen), 32'd0);
        snd_busy = 1'b0;
        handshake("t5", 8'h82, w);
        check("t5_latency", 32'(w), 32'd1);
        repeat (TO - 1) @(negedge clk);
        check("t5_pre_expiry", 32'(rsp_valid), 32'd0);
        respond("t5", 8'h06, 2'b00, 3'b110);

        // rcv_ready while IDLE is dropped
        rcv_data  = 8'h01;
        rcv_ready = 1'b1;
        @(negedge clk);
        rcv_ready = 1'b0;
        check("t6_no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("t6_no_rsp_late", 32'(rsp_valid), 32'd0);
        check("t6_data_held", 32'(rsp_data), 32'd6);

        // reset while in SEND_WAIT
        issue(2'b11, 3'b000, 8'hAA);
        w = 0;
        while (!snd_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("t7_snd_ready", 32'(snd_ready), 32'd1);
        reset_n = 1'b0;
        #1;
        check("t7_snd_ready_drop", 32'(snd_ready), 32'd0);
        check("t7_snd_data_clr", 32'(snd_data), 32'd0);
        check("t7_cmd_ready_rst", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid || snd_ready) seen++;
        end
        check("t7_quiet_after_rst", 32'(seen), 32'd0);
        check("t7_cmd_ready_after", 32'(cmd_ready), 32'd1);
        check("t7_status_clr", 32'(rsp_status), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
